scalar_multiplication: RTL and testbench
========================================

Name:
scalar_multiplication

Overview:
- Computes Q = k·P on secp256k1 (y² = x³ + 7 over GF(p), p = 2^256 − 2^32 − 977) in affine coordinates.
- Free-running: starts automatically whenever its operands change, so it needs no start strobe.
- Sits in the ECC datapath as the point-multiply engine feeding key-derivation and signature logic.
- Iterative and multi-cycle; one shared modular multiplier does all field arithmetic.

Parameters:
- None. Curve constants (P, N, B=7) are fixed and live in the shared package.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- x1  input  256  base point X, affine, < p
- y1  input  256  base point Y, affine, < p
- k  input  256  scalar, full 256 bits used as-is, no reduction mod n
- x_output  output  256  result X, affine
- y_output  output  256  result Y, affine
- done  output  1  high when outputs equal k·(x1,y1) for the currently latched operands

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset:
  - x_output, y_output, done and all operand latches go to 0.
  - FSM goes to IDLE.
  - Reset mid-operation aborts the computation immediately.
- Start:
  - In IDLE or any busy state, the block compares {x1,y1,k} with its latched copies every cycle.
  - On any mismatch, it latches the new operands, clears done, and enters LOAD next cycle.
  - A change during computation aborts and restarts with the new values.
- Algorithm:
  - Left-to-right double-and-add over k[255:0] in Jacobian coordinates (X,Y,Z), a = 0.
  - The accumulator starts at infinity, encoded Z = 0.
  - Each bit: DOUBLE; then ADD the base point if the bit is 1.
  - Mixed add with an affine base: doubling is handled when the accumulator equals the base; infinity is returned when the accumulator equals the negated base.
- Finalise:
  - If Z = 0, the result is (0,0).
  - Otherwise compute Z⁻¹ = Z^(p−2) by square-and-multiply, then x = X·Z⁻², y = Y·Z⁻³.
- FSM states: IDLE, LOAD, DBL, ADD, INV, AFFINE, DONE.
  - DONE writes the outputs, sets done = 1, and returns to IDLE.
- Field arithmetic:
  - One bit-serial interleaved modular multiplier, 256 cycles per product.
  - Modular add/subtract are combinational with one conditional correction.
  - Every intermediate value stays in [0, p−1]; widths are 257 bits internally for carries.
- Outputs:
  - x_output, y_output hold the previous result (or 0 after reset) until DONE; they never show partial values.
  - Worst-case latency for all k is 2^24 cycles or fewer; the bench waits for done.
- Boundary cases:
  - k = 0 → (0,0).
  - k = n → (0,0).
  - k ≥ n → wraps naturally by group order.
- Off-curve inputs are not checked; the result is unspecified but the FSM must still terminate.

Decomposition:
- Package secp256k1_pkg holds:
  - constants P, N, B, GX, GY
  - the FSM state enum
  - a 256-bit field-element typedef
- One sub-module, mod_mul:
  - start/busy/done handshake; inputs a, b < p; output a·b mod p after 256+2 cycles.
- Top level: FSM, Jacobian register file, mod add/sub, operand-change detector.

Test Plan:
1. Reset held 2 cycles → x_output = y_output = 0, done = 0.
2. (x1,y1) = G (79BE667E…16F81798, 483ADA77…FB10D4B8), k = 1 → wait done; outputs equal G exactly.
3. G, k = 2 → x = C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, y = 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A.
4. G, k = 3 → x = F9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9, y = 388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672.
5. G, k = 0 then k = n → (0,0) with done = 1. k = n−1 → (Gx, B7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777).
6. Change k mid-computation and assert reset mid-computation:
   - after a change, done stays low and the final outputs match the new k only;
   - after reset, outputs are 0 next cycle;
   - k = all-ones equals k = 14551231950B75FC4402DA1732FC9BEBE (mod-n equivalent), checked against a software model.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// secp256k1 curve constants, FSM state and micro-op types,
// modular add/sub helpers and the point-formula micro-programs.
package secp256k1_pkg;

    typedef logic [255:0] fe_t;

    localparam fe_t P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam fe_t N =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam fe_t B = 256'd7;
    localparam fe_t GX =
        256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam fe_t GY =
        256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam fe_t ONE = 256'd1;
    // Fermat exponent for inversion
    localparam fe_t E_INV = P - 256'd2;

    typedef enum logic [2:0] {
        IDLE, LOAD, DBL, ADD, INV, AFFINE, DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_END, OP_MUL, OP_ADD, OP_SUB, OP_CHK
    } op_e;

    // register file slots: accumulator, base point, temporaries
    localparam logic [2:0] RX  = 3'd0;
    localparam logic [2:0] RY  = 3'd1;
    localparam logic [2:0] RZ  = 3'd2;
    localparam logic [2:0] RBX = 3'd3;
    localparam logic [2:0] RBY = 3'd4;
    localparam logic [2:0] T0  = 3'd5;
    localparam logic [2:0] T1  = 3'd6;
    localparam logic [2:0] T2  = 3'd7;

    typedef struct packed {
        op_e        op;
        logic [2:0] dst;
        logic [2:0] a;
        logic [2:0] b;
    } uop_t;

    function automatic fe_t mod_add(fe_t a, fe_t b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    // a - b + P wraps correctly in 256 bits when a < b
    function automatic fe_t mod_sub(fe_t a, fe_t b);
        return (a >= b) ? a - b : a - b + P;
    endfunction

    function automatic uop_t mk(op_e op, logic [2:0] d,
                                logic [2:0] a, logic [2:0] b);
        return '{op: op, dst: d, a: a, b: b};
    endfunction

    // Jacobian doubling (a=0), mixed add, one inversion
    // square/multiply step, and the affine conversion.
    function automatic uop_t prog(state_e st, logic [4:0] step);
        uop_t u;
        u = mk(OP_END, RX, RX, RX);
        case (st)
            DBL: case (step)
                5'd0:  u = mk(OP_MUL, T0, RY, RY);
                5'd1:  u = mk(OP_MUL, T1, RX, T0);
                5'd2:  u = mk(OP_ADD, T1, T1, T1);
                5'd3:  u = mk(OP_ADD, T1, T1, T1);
                5'd4:  u = mk(OP_MUL, T2, RX, RX);
                5'd5:  u = mk(OP_ADD, RX, T2, T2);
                5'd6:  u = mk(OP_ADD, T2, RX, T2);
                5'd7:  u = mk(OP_MUL, T0, T0, T0);
                5'd8:  u = mk(OP_MUL, RZ, RY, RZ);
                5'd9:  u = mk(OP_ADD, RZ, RZ, RZ);
                5'd10: u = mk(OP_MUL, RX, T2, T2);
                5'd11: u = mk(OP_SUB, RX, RX, T1);
                5'd12: u = mk(OP_SUB, RX, RX, T1);
                5'd13: u = mk(OP_SUB, T1, T1, RX);
                5'd14: u = mk(OP_MUL, RY, T2, T1);
                5'd15: u = mk(OP_ADD, T0, T0, T0);
                5'd16: u = mk(OP_ADD, T0, T0, T0);
                5'd17: u = mk(OP_ADD, T0, T0, T0);
                5'd18: u = mk(OP_SUB, RY, RY, T0);
                default: ;
            endcase
            ADD: case (step)
                5'd0:  u = mk(OP_MUL, T0, RZ, RZ);
                5'd1:  u = mk(OP_MUL, T1, RBX, T0);
                5'd2:  u = mk(OP_MUL, T0, RZ, T0);
                5'd3:  u = mk(OP_MUL, T0, RBY, T0);
                5'd4:  u = mk(OP_SUB, T1, T1, RX);
                5'd5:  u = mk(OP_SUB, T0, T0, RY);
                5'd6:  u = mk(OP_CHK, T0, T0, T0);
                5'd7:  u = mk(OP_MUL, T2, T1, T1);
                5'd8:  u = mk(OP_MUL, RZ, RZ, T1);
                5'd9:  u = mk(OP_MUL, T1, T1, T2);
                5'd10: u = mk(OP_MUL, T2, RX, T2);
                5'd11: u = mk(OP_MUL, RX, T0, T0);
                5'd12: u = mk(OP_SUB, RX, RX, T1);
                5'd13: u = mk(OP_SUB, RX, RX, T2);
                5'd14: u = mk(OP_SUB, RX, RX, T2);
                5'd15: u = mk(OP_SUB, T2, T2, RX);
                5'd16: u = mk(OP_MUL, T2, T0, T2);
                5'd17: u = mk(OP_MUL, T1, RY, T1);
                5'd18: u = mk(OP_SUB, RY, T2, T1);
                default: ;
            endcase
            INV: case (step)
                5'd0: u = mk(OP_MUL, T0, T0, T0);
                5'd1: u = mk(OP_MUL, T0, T0, RZ);
                default: ;
            endcase
            AFFINE: case (step)
                5'd0: u = mk(OP_MUL, T1, T0, T0);
                5'd1: u = mk(OP_MUL, RX, RX, T1);
                5'd2: u = mk(OP_MUL, T1, T1, T0);
                5'd3: u = mk(OP_MUL, RY, RY, T1);
                default: ;
            endcase
            default: ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved multiplier mod P, MSB of b first.
// Ports: start (ignored while busy), a/b < P, busy, done pulse, p result.
module mod_mul
    import secp256k1_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  fe_t  a,
    input  fe_t  b,
    output logic busy,
    output logic done,
    output fe_t  p
);

    fe_t        a_q, a_d, b_q, b_d, r_q, r_d, r2;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d, done_q, done_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        r2     = mod_add(r_q, r_q);
        if (busy_q) begin
            r_d   = b_q[255] ? mod_add(r2, a_q) : r2;
            b_d   = {b_q[254:0], 1'b0};
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            a_d    = a;
            b_d    = b;
            r_d    = '0;
            cnt_d  = 8'd255;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = r_q;

endmodule

// File: rtl/scalar_multiplication.sv
// Free-running k*(x1,y1) on secp256k1; restarts on any operand change.
// Ports: clk, reset, x1/y1/k operands, x_output/y_output result, done.
module scalar_multiplication
    import secp256k1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] x1,
    input  logic [255:0] y1,
    input  logic [255:0] k,
    output logic [255:0] x_output,
    output logic [255:0] y_output,
    output logic         done
);

    state_e     state_q, state_d;
    logic [4:0] step_q, step_d;
    logic [7:0] bit_q, bit_d;
    logic       dbl_repl_q, dbl_repl_d;
    logic       mul_wait_q, mul_wait_d;
    logic       done_q, done_d;
    fe_t        x1_q, x1_d, y1_q, y1_d, k_q, k_d;
    fe_t        x_out_q, x_out_d, y_out_q, y_out_d;
    fe_t        rf_q [8];
    fe_t        rf_d [8];

    uop_t uop;
    logic mul_start, mul_busy, mul_done;
    fe_t  mul_a, mul_b, mul_p;
    logic nxt_bit, after_dbl;

    mod_mul u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        uop        = prog(state_q, step_q);
        mul_a      = rf_q[uop.a];
        mul_b      = rf_q[uop.b];
        mul_start  = 1'b0;
        nxt_bit    = 1'b0;
        after_dbl  = 1'b0;
        state_d    = state_q;
        step_d     = step_q;
        bit_d      = bit_q;
        dbl_repl_d = dbl_repl_q;
        mul_wait_d = mul_wait_q;
        done_d     = done_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        k_d        = k_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        rf_d       = rf_q;

        unique case (state_q)
            IDLE: ;
            LOAD: begin
                rf_d[RX]   = '0;
                rf_d[RY]   = '0;
                rf_d[RZ]   = '0;
                rf_d[RBX]  = x1_q;
                rf_d[RBY]  = y1_q;
                bit_d      = 8'd255;
                step_d     = '0;
                dbl_repl_d = 1'b0;
                state_d    = DBL;
            end
            DBL, ADD, INV, AFFINE: begin
                // doubling infinity is infinity; adding to it loads the base
                if (state_q == DBL && step_q == 5'd0 && rf_q[RZ] == '0) begin
                    after_dbl = 1'b1;
                end else if (state_q == ADD && step_q == 5'd0
                             && rf_q[RZ] == '0) begin
                    rf_d[RX] = rf_q[RBX];
                    rf_d[RY] = rf_q[RBY];
                    rf_d[RZ] = ONE;
                    nxt_bit  = 1'b1;
                end else begin
                    unique case (uop.op)
                        OP_ADD: begin
                            rf_d[uop.dst] = mod_add(rf_q[uop.a], rf_q[uop.b]);
                            step_d = step_q + 5'd1;
                        end
                        OP_SUB: begin
                            rf_d[uop.dst] = mod_sub(rf_q[uop.a], rf_q[uop.b]);
                            step_d = step_q + 5'd1;
                        end
                        OP_MUL: begin
                            if (state_q == INV && step_q == 5'd1
                                && !E_INV[bit_q]) begin
                                step_d = step_q + 5'd1;
                            end else if (!mul_wait_q) begin
                                if (!mul_busy) begin
                                    mul_start  = 1'b1;
                                    mul_wait_d = 1'b1;
                                end
                            end else if (mul_done) begin
                                rf_d[uop.dst] = mul_p;
                                mul_wait_d    = 1'b0;
                                step_d        = step_q + 5'd1;
                            end
                        end
                        OP_CHK: begin
                            // H == 0: same x, so either acc == base or acc == -base
                            if (rf_q[T1] == '0) begin
                                if (rf_q[T0] == '0) begin
                                    state_d    = DBL;
                                    step_d     = '0;
                                    dbl_repl_d = 1'b1;
                                end else begin
                                    rf_d[RZ] = '0;
                                    nxt_bit  = 1'b1;
                                end
                            end else begin
                                step_d = step_q + 5'd1;
                            end
                        end
                        OP_END: begin
                            if (state_q == DBL) begin
                                after_dbl = 1'b1;
                            end else if (state_q == ADD) begin
                                nxt_bit = 1'b1;
                            end else if (state_q == INV) begin
                                step_d = '0;
                                if (bit_q == 8'd0) state_d = AFFINE;
                                else bit_d = bit_q - 8'd1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DONE: begin
                x_out_d = (rf_q[RZ] == '0) ? '0 : rf_q[RX];
                y_out_d = (rf_q[RZ] == '0) ? '0 : rf_q[RY];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (after_dbl) begin
            if (dbl_repl_q) begin
                dbl_repl_d = 1'b0;
                nxt_bit    = 1'b1;
            end else if (k_q[bit_q]) begin
                state_d = ADD;
                step_d  = '0;
            end else begin
                nxt_bit = 1'b1;
            end
        end

        if (nxt_bit) begin
            step_d = '0;
            if (bit_q != 8'd0) begin
                bit_d   = bit_q - 8'd1;
                state_d = DBL;
            end else if (rf_d[RZ] == '0 || rf_d[RZ] == ONE) begin
                // infinity or already affine: no inversion needed
                state_d = DONE;
            end else begin
                rf_d[T0] = rf_d[RZ];
                bit_d    = 8'd254;
                state_d  = INV;
            end
        end

        if ({x1, y1, k} != {x1_q, y1_q, k_q}) begin
            x1_d       = x1;
            y1_d       = y1;
            k_d        = k;
            done_d     = 1'b0;
            mul_wait_d = 1'b0;
            state_d    = LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            bit_q      <= '0;
            dbl_repl_q <= 1'b0;
            mul_wait_q <= 1'b0;
            done_q     <= 1'b0;
            x1_q       <= '0;
            y1_q       <= '0;
            k_q        <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bit_q      <= bit_d;
            dbl_repl_q <= dbl_repl_d;
            mul_wait_q <= mul_wait_d;
            done_q     <= done_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            k_q        <= k_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            rf_q       <= rf_d;
        end
    end

    assign x_output = x_out_q;
    assign y_output = y_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_scalar_multiplication.sv
// Directed bench for scalar_multiplication: vector table plus
// operand-change, mid-run reset and reduced-scalar model checks.
module tb_scalar_multiplication;
    import secp256k1_pkg::*;

    localparam int MAXC = 2000000;
    localparam fe_t GYN =
        256'hB7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777;
    localparam fe_t X2 =
        256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam fe_t Y2 =
        256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam fe_t X3 =
        256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam fe_t Y3 =
        256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;

    logic clk = 1'b0;
    logic reset;
    fe_t  x1, y1, k, xo, yo;
    logic done;

    always #5 clk = ~clk;

    scalar_multiplication dut (
        .clk      (clk),
        .reset    (reset),
        .x1       (x1),
        .y1       (y1),
        .k        (k),
        .x_output (xo),
        .y_output (yo),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        fe_t k;
        fe_t ex;
        fe_t ey;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input fe_t act, input fe_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (!done && c < MAXC) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got done=%0b want 1", nm, done);
        end
    endtask

    task automatic apply(input fe_t px, input fe_t py, input fe_t pk,
                         input string nm);
        @(negedge clk);
        x1 = px;
        y1 = py;
        k  = pk;
        @(negedge clk);
        chk({nm, "_clr"}, fe_t'(done), '0);
    endtask

    // independent affine reference model using wide % arithmetic
    function automatic fe_t fmul(fe_t a, fe_t b);
        logic [511:0] t;
        t = {256'd0, a} * {256'd0, b};
        t = t % {256'd0, P};
        return t[255:0];
    endfunction

    function automatic fe_t fadd(fe_t a, fe_t b);
        logic [256:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
        return s[255:0];
    endfunction

    function automatic fe_t fsub(fe_t a, fe_t b);
        return fadd(a, P - b);
    endfunction

    function automatic fe_t finv(fe_t a);
        fe_t r;
        fe_t e;
        r = 256'd1;
        e = P - 256'd2;
        for (int i = 255; i >= 0; i--) begin
            r = fmul(r, r);
            if (e[i]) r = fmul(r, a);
        end
        return r;
    endfunction

    task automatic pdbl(input fe_t ax, input fe_t ay,
                        output fe_t rx, output fe_t ry);
        fe_t l;
        l  = fmul(fmul(256'd3, fmul(ax, ax)), finv(fadd(ay, ay)));
        rx = fsub(fmul(l, l), fadd(ax, ax));
        ry = fsub(fmul(l, fsub(ax, rx)), ay);
    endtask

    task automatic ec_mul(input fe_t kk, output fe_t rx, output fe_t ry);
        fe_t  s, ax, ay, nx, ny, l;
        logic inf;
        s   = kk % N;
        inf = 1'b1;
        ax  = '0;
        ay  = '0;
        for (int i = 255; i >= 0; i--) begin
            if (!inf) begin
                pdbl(ax, ay, nx, ny);
                ax = nx;
                ay = ny;
            end
            if (s[i]) begin
                if (inf) begin
                    ax  = GX;
                    ay  = GY;
                    inf = 1'b0;
                end else if (ax == GX) begin
                    inf = 1'b1;
                end else begin
                    l  = fmul(fsub(GY, ay), finv(fsub(GX, ax)));
                    nx = fsub(fsub(fmul(l, l), ax), GX);
                    ay = fsub(fmul(l, fsub(ax, nx)), ay);
                    ax = nx;
                end
            end
        end
        rx = inf ? '0 : ax;
        ry = inf ? '0 : ay;
    endtask

    initial begin
        fe_t mx, my, ones;
        ones = '1;

        tv[0] = '{k: 256'd1, ex: GX, ey: GY};
        tv[1] = '{k: 256'd2, ex: X2, ey: Y2};
        tv[2] = '{k: 256'd3, ex: X3, ey: Y3};
        tv[3] = '{k: 256'd0, ex: '0, ey: '0};
        tv[4] = '{k: N, ex: '0, ey: '0};
        tv[5] = '{k: N - 256'd1, ex: GX, ey: GYN};

        reset = 1'b1;
        x1 = '0;
        y1 = '0;
        k  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", xo, '0);
        chk("rst_y", yo, '0);
        chk("rst_done", fe_t'(done), '0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply(GX, GY, tv[i].k, $sformatf("vec%0d", i));
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_x", i), xo, tv[i].ex);
            chk($sformatf("vec%0d_y", i), yo, tv[i].ey);
            chk($sformatf("vec%0d_done", i), fe_t'(done), 256'd1);
        end

        // change k while busy: old result held, only new k reported
        apply(GX, GY, 256'd3, "mid3");
        repeat (3000) @(negedge clk);
        chk("mid_hold_x", xo, GX);
        chk("mid_hold_y", yo, GYN);
        chk("mid_busy_done", fe_t'(done), '0);
        apply(GX, GY, 256'd2, "mid2");
        wait_done("mid2");
        chk("mid2_x", xo, X2);
        chk("mid2_y", yo, Y2);

        // reset while busy clears outputs on the next cycle
        apply(GX, GY, 256'd3, "rst3");
        repeat (2000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_x", xo, '0);
        chk("midrst_y", yo, '0);
        chk("midrst_done", fe_t'(done), '0);
        reset = 1'b0;

        // all-ones scalar against the model of its reduction mod n
        ec_mul(256'h14551231950B75FC4402DA1732FC9BEBE, mx, my);
        apply(GX, GY, ones, "ones");
        wait_done("ones");
        chk("ones_x", xo, mx);
        chk("ones_y", yo, my);
        chk("ones_done", fe_t'(done), 256'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
